qpsk_symbol_mapper: RTL
=======================

QPSK_SYMBOL_MAPPER -- requirements
Module: qpsk_symbol_mapper

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 8, width of bytes read from the upstream fifo (even values only).
REQ-002 SHALL have parameter SPS, default 4, clocks each symbol is held (minimum 2).
REQ-003 SHALL have parameter OUT_W, default 4, signed width of i_out/q_out.
REQ-004 SHALL have parameter AMP, default 7, symbol magnitude (must fit in OUT_W signed).
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port tx_en  input  1  permits new fifo reads while high.
REQ-008 SHALL have port fifo_empty  input  1  empty flag of the upstream fifo.
REQ-009 SHALL have port fifo_data  input  FIFO_WIDTH  fifo data_out, valid the cycle after a read is accepted.
REQ-010 SHALL have port fifo_read_en  output  1  one-cycle fifo read request.
REQ-011 SHALL have port i_out  output  OUT_W  signed in-phase level.
REQ-012 SHALL have port q_out  output  OUT_W  signed quadrature level.
REQ-013 SHALL have port sym_valid  output  1  i_out/q_out carry a symbol.
REQ-014 SHALL have port sym_start  output  1  pulse on first clock of each symbol.
REQ-015 SHALL have port underrun  output  1  one-cycle pulse when the stream stops for lack of data.

Function
REQ-016 SHALL implement states IDLE, FETCH, LOAD, SEND; all outputs registered.
REQ-017 IDLE: tx_en=1 and fifo_empty=0 sampled at an edge -> FETCH, fifo_read_en=1 for exactly that next cycle.
REQ-018 FETCH -> LOAD unconditionally; LOAD captures fifo_data into the shift register at its closing edge -> SEND.
REQ-019 First symbol SHALL appear (sym_valid=1, sym_start=1) exactly 3 clocks after the edge that sampled the IDLE read condition.
REQ-020 SEND: byte split into FIFO_WIDTH/2 dibits, MSB dibit first; each held SPS clocks via a symbol counter 0..SPS-1.
REQ-021 Gray mapping {b1,b0}: 00->(+AMP,+AMP), 01->(-AMP,+AMP), 11->(-AMP,-AMP), 10->(+AMP,-AMP) as (i,q).
REQ-022 Prefetch: when the counter is 0 of the last dibit and tx_en=1, fifo_empty=0, SHALL pulse fifo_read_en once and capture fifo_data two clocks later into a next-byte register with valid flag.
REQ-023 End of last dibit with next-byte valid: SHALL load it and start the next symbol on the following clock with no gap (continuous sym_valid).
REQ-024 End of last dibit without next-byte valid: SHALL return to IDLE, sym_valid=0, i_out=q_out=0; underrun=1 for that clock if tx_en=1, else 0.
REQ-025 tx_en falling mid-byte SHALL NOT truncate the byte; only new reads are blocked.
REQ-026 fifo_read_en SHALL never assert while fifo_empty=1 was sampled at the deciding edge, and never twice per byte.
REQ-027 fifo_empty and tx_en rising together in IDLE: the read condition is evaluated on sampled values only; no read if either was low at that edge.

Reset
REQ-028 reset=1 SHALL immediately force state IDLE, counters 0, next-byte valid 0, fifo_read_en=0, i_out=0, q_out=0, sym_valid=0, sym_start=0, underrun=0.
REQ-029 Reset asserted mid-SEND SHALL discard the current and prefetched bytes; no symbol emitted after release until a new read completes.
REQ-030 After reset release, first fifo_read_en no earlier than the second rising edge.

Verification
REQ-031 Single byte 0xB4, tx_en=1, fifo then empty -> symbols (+7,-7),(-7,-7),(-7,+7),(+7,+7), each 4 clocks, then underrun pulse, sym_valid=0.
REQ-032 Bytes 0x00,0xFF back-to-back -> 32 consecutive clocks of sym_valid=1, 4 of (+7,+7) symbols then 4 of (-7,-7), exactly 2 fifo_read_en pulses, no underrun.
REQ-033 Latency: read condition sampled at edge t -> fifo_read_en high in cycle t+1, sym_start first high in cycle t+3.
REQ-034 tx_en dropped during second dibit of 0x1B with more data queued -> remaining dibits 10,11 emitted, no further read, underrun=0, return to IDLE.
REQ-035 reset asserted during third symbol of 0xB4 -> outputs zero asynchronously; after release with fifo empty, sym_valid stays 0 and fifo_read_en stays 0.
REQ-036 fifo_empty=1 throughout with tx_en=1 -> fifo_read_en never asserts, underrun never pulses.

Source files
------------

// File: rtl/qpsk_symbol_mapper.sv
// QPSK symbol mapper: pulls bytes from an upstream FIFO, splits each byte into
// dibits (MSB dibit first), Gray-maps each dibit to an (I,Q) level pair, and
// holds every symbol for SPS clocks. The next byte is prefetched during the
// last dibit, so consecutive bytes stream with no gap in sym_valid.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no symbol on the outputs; waiting for tx_en with a non-empty fifo
// FETCH | fifo_read_en is high for this single cycle
// LOAD  | fifo_data is valid; captured into the shift register at the edge
// SEND  | emitting dibits, each held SPS clocks; prefetching the next byte
module qpsk_symbol_mapper #(
    parameter int FIFO_WIDTH = 8,
    parameter int SPS        = 4,
    parameter int OUT_W      = 4,
    parameter int AMP        = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tx_en,
    input  logic                    fifo_empty,
    input  logic [FIFO_WIDTH-1:0]   fifo_data,
    output logic                    fifo_read_en,
    output logic signed [OUT_W-1:0] i_out,
    output logic signed [OUT_W-1:0] q_out,
    output logic                    sym_valid,
    output logic                    sym_start,
    output logic                    underrun
);

    localparam int N_DIBIT = FIFO_WIDTH / 2;
    localparam int CNT_W   = $clog2(SPS);
    localparam int IDX_W   = (N_DIBIT > 1) ? $clog2(N_DIBIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIBIT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, SEND} state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [FIFO_WIDTH-1:0] r_shift;
    logic [FIFO_WIDTH-1:0] r_nb;
    logic                  r_nb_valid;
    logic                  r_pf_due;   // fifo_data carries the prefetched byte this cycle
    logic                  r_armed;    // keeps the first read off the first edge after reset
    logic [FIFO_WIDTH-1:0] w_shift_nxt;

    assign w_shift_nxt = r_shift << 2;

    // Gray mapping: b0 selects the sign of I, b1 selects the sign of Q.
    function automatic logic [2*OUT_W-1:0] map_dibit(input logic [1:0] d);
        logic [OUT_W-1:0] p;
        logic [OUT_W-1:0] n;
        p = OUT_W'(AMP);
        n = OUT_W'(-AMP);
        map_dibit = {(d[0] ? n : p), (d[1] ? n : p)};
    endfunction

    // Sequencer, counters, prefetch and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_nb         <= '0;
            r_nb_valid   <= 1'b0;
            r_pf_due     <= 1'b0;
            r_armed      <= 1'b0;
            fifo_read_en <= 1'b0;
            i_out        <= '0;
            q_out        <= '0;
            sym_valid    <= 1'b0;
            sym_start    <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            r_armed      <= 1'b1;
            fifo_read_en <= 1'b0;
            sym_start    <= 1'b0;
            underrun     <= 1'b0;
            r_pf_due     <= 1'b0;
            case (r_state)
                IDLE: begin
                    sym_valid <= 1'b0;
                    i_out     <= '0;
                    q_out     <= '0;
                    if (r_armed && tx_en && !fifo_empty) begin
                        r_state      <= FETCH;
                        fifo_read_en <= 1'b1;
                    end
                end
                FETCH: begin
                    r_state <= LOAD;
                end
                LOAD: begin
                    r_shift        <= fifo_data;
                    {i_out, q_out} <= map_dibit(fifo_data[FIFO_WIDTH-1 -: 2]);
                    sym_valid      <= 1'b1;
                    sym_start      <= 1'b1;
                    r_cnt          <= '0;
                    r_idx          <= '0;
                    r_state        <= SEND;
                end
                SEND: begin
                    r_pf_due <= fifo_read_en;
                    if (r_pf_due) begin
                        r_nb       <= fifo_data;
                        r_nb_valid <= 1'b1;
                    end
                    // one prefetch per byte, decided on the first clock of the last dibit
                    if (r_cnt == '0 && r_idx == IDX_LAST && tx_en && !fifo_empty &&
                        !r_nb_valid && !r_pf_due && !fifo_read_en) begin
                        fifo_read_en <= 1'b1;
                    end
                    if (r_cnt != CNT_LAST) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else if (r_idx != IDX_LAST) begin
                        r_cnt          <= '0;
                        r_idx          <= r_idx + IDX_W'(1);
                        r_shift        <= w_shift_nxt;
                        {i_out, q_out} <= map_dibit(w_shift_nxt[FIFO_WIDTH-1 -: 2]);
                        sym_start      <= 1'b1;
                    end else if (r_nb_valid) begin
                        r_cnt          <= '0;
                        r_idx          <= '0;
                        r_shift        <= r_nb;
                        r_nb_valid     <= 1'b0;
                        {i_out, q_out} <= map_dibit(r_nb[FIFO_WIDTH-1 -: 2]);
                        sym_start      <= 1'b1;
                    end else if (r_pf_due) begin
                        // prefetched byte arrives exactly at the byte boundary
                        r_cnt          <= '0;
                        r_idx          <= '0;
                        r_shift        <= fifo_data;
                        r_nb_valid     <= 1'b0;
                        {i_out, q_out} <= map_dibit(fifo_data[FIFO_WIDTH-1 -: 2]);
                        sym_start      <= 1'b1;
                    end else if (fifo_read_en) begin
                        // very short SPS: read still in flight, let LOAD catch the byte
                        r_pf_due  <= 1'b0;
                        r_state   <= LOAD;
                        sym_valid <= 1'b0;
                        i_out     <= '0;
                        q_out     <= '0;
                    end else begin
                        r_state   <= IDLE;
                        sym_valid <= 1'b0;
                        i_out     <= '0;
                        q_out     <= '0;
                        underrun  <= tx_en;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
